demux3_route: RTL and testbench

DEMUX3_ROUTE -- requirements
Module: demux3_route

---
 rtl/demux3_pkg.sv | 27 ++
 rtl/demux3_slot.sv | 33 +++
 rtl/demux3_route.sv | 83 ++++++++
 tb/tb_demux3_route.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux3_pkg.sv
// Select encoding and decode helper shared by the demux3_route slice.
// The illegal-select handling (DEMUX3_ERR_EN) is applied in the top level; this package is build-independent.
package demux3_pkg;

    localparam int unsigned NUM_PORTS = 3;
    localparam int unsigned SEL_W     = 2;

    typedef logic [SEL_W-1:0] sel_t;

    localparam sel_t SEL_P0  = 2'b00;
    localparam sel_t SEL_P1  = 2'b01;
    localparam sel_t SEL_P2  = 2'b10;
    localparam sel_t SEL_BAD = 2'b11;

    // One-hot destination for a select; SEL_BAD lands on port 2 because sel[1] wins.
    function automatic logic [NUM_PORTS-1:0] sel_onehot(input sel_t sel);
        logic [NUM_PORTS-1:0] hot;
        hot = 3'b001;
        if (sel[1]) begin
            hot = 3'b100;
        end else if (sel[0]) begin
            hot = 3'b010;
        end
        return hot;
    endfunction

endpackage

// File: rtl/demux3_slot.sv
// One-entry output register for a single demux port: load, drain, hold and valid tracking.
module demux3_slot
    import demux3_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] q,
    output logic             space_c
);

    // Room for a new word when empty or when the held word leaves this edge.
    assign space_c = ~valid | ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= data;
        end else if (ready) begin
            // q is left as-is after a drain; only valid marks it stale
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux3_route.sv
// 1-to-3 demultiplexer with a one-entry register per output port.
// Optional DEMUX3_ERR_EN: select 11 is consumed and dropped and sets a sticky err flag; otherwise it routes to port 2.
module demux3_route
    import demux3_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [SEL_W-1:0]     in_sel,
    output logic [NUM_PORTS-1:0] out_valid,
    input  logic [NUM_PORTS-1:0] out_ready,
    output logic [WIDTH-1:0]     out_data0,
    output logic [WIDTH-1:0]     out_data1,
    output logic [WIDTH-1:0]     out_data2
`ifdef DEMUX3_ERR_EN
    ,
    output logic                 err
`endif
);

    logic [NUM_PORTS-1:0] hit;
    logic [NUM_PORTS-1:0] space;
    logic [NUM_PORTS-1:0] load;
    logic [WIDTH-1:0]     slot_q [NUM_PORTS];

`ifdef DEMUX3_ERR_EN
    logic bad;

    // An illegal select targets no port and is flagged instead.
    always_comb begin
        hit = sel_onehot(sel_t'(in_sel));
        bad = 1'b0;
        if (sel_t'(in_sel) == SEL_BAD) begin
            hit = '0;
            bad = 1'b1;
        end
    end

    // A dropped word is always accepted.
    assign in_ready = bad | (|(hit & space));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if (in_valid && bad) begin
            err <= 1'b1;
        end
    end
`else
    always_comb begin
        hit = sel_onehot(sel_t'(in_sel));
    end

    assign in_ready = |(hit & space);
`endif

    // Only the selected port gates in_ready, so stalled neighbours never block.
    assign load = {NUM_PORTS{in_valid & in_ready}} & hit;

    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_slot
        demux3_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk     (clk),
            .reset   (reset),
            .load    (load[k]),
            .data    (in_data),
            .ready   (out_ready[k]),
            .valid   (out_valid[k]),
            .q       (slot_q[k]),
            .space_c (space[k])
        );
    end

    assign out_data0 = slot_q[0];
    assign out_data1 = slot_q[1];
    assign out_data2 = slot_q[2];

endmodule

// File: tb/tb_demux3_route.sv
// Self-checking bench for demux3_route (WIDTH=32) with a per-port scoreboard; builds with or without DEMUX3_ERR_EN.
module tb_demux3_route;

    localparam int unsigned W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [1:0]    in_sel;
    logic [2:0]    out_valid;
    logic [2:0]    out_ready;
    logic [W-1:0]  out_data0;
    logic [W-1:0]  out_data1;
    logic [W-1:0]  out_data2;
`ifdef DEMUX3_ERR_EN
    logic          err;
`endif

    int unsigned   n_tests = 0;
    int unsigned   n_fail  = 0;
    bit            mon_en  = 1'b0;
    logic [W-1:0]  sb [3][$];
    logic [W-1:0]  od [3];

    demux3_route #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_data2 (out_data2)
`ifdef DEMUX3_ERR_EN
        ,
        .err       (err)
`endif
    );

    always #5 clk = ~clk;

    assign od[0] = out_data0;
    assign od[1] = out_data1;
    assign od[2] = out_data2;

    function automatic int port_of(input logic [1:0] sel);
        if (sel[1]) return 2;
        if (sel[0]) return 1;
        return 0;
    endfunction

    // Scoreboard: inputs are stable between posedge+1 and the next posedge, so judge the coming edge at negedge.
    always @(negedge clk) begin
        if (reset) begin
            for (int k = 0; k < 3; k++) sb[k].delete();
        end else if (mon_en) begin
            logic exp_rdy;
            bool_drop_blk: begin
                bit drop;
                int p;
                p = port_of(in_sel);
                drop = 1'b0;
`ifdef DEMUX3_ERR_EN
                drop = (in_sel == 2'b11);
`endif
                exp_rdy = drop ? 1'b1 : ((sb[p].size() == 0) || out_ready[p]);
                n_tests++;
                if (in_ready !== exp_rdy) begin
                    n_fail++;
                    $display("FAIL sb_in_ready: got %b want %b (sel=%b)", in_ready, exp_rdy, in_sel);
                end
                for (int k = 0; k < 3; k++) begin
                    n_tests++;
                    if (out_valid[k] !== (sb[k].size() != 0)) begin
                        n_fail++;
                        $display("FAIL sb_valid%0d: got %b want %b", k, out_valid[k], sb[k].size() != 0);
                    end else if (out_valid[k]) begin
                        n_tests++;
                        if (od[k] !== sb[k][0]) begin
                            n_fail++;
                            $display("FAIL sb_data%0d: got %h want %h", k, od[k], sb[k][0]);
                        end
                    end
                    if (out_valid[k] && out_ready[k] && sb[k].size() != 0) void'(sb[k].pop_front());
                end
                if (in_valid && in_ready === 1'b1 && !drop) sb[p].push_back(in_data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = 2'b00; out_ready = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (out_valid !== 3'b000 || out_data0 !== '0 || out_data1 !== '0 || out_data2 !== '0) begin
            n_fail++;
            $display("FAIL reset_out: got v=%b d0=%h d1=%h d2=%h want all 0", out_valid, out_data0, out_data1, out_data2);
        end
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
`ifdef DEMUX3_ERR_EN
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_err: got %b want 0", err);
        end
`endif
        reset = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_basic();
        in_valid = 1'b1; in_sel = 2'b01; in_data = 32'hA5;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_ready: got %b want 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 3'b010 || out_data1 !== 32'hA5) begin
            n_fail++;
            $display("FAIL basic_out: got v=%b d1=%h want v=010 d1=a5", out_valid, out_data1);
        end
        out_ready = 3'b010;
        step();
        out_ready = 3'b000;
        n_tests++;
        if (out_valid !== 3'b000 || out_data1 !== 32'hA5) begin
            n_fail++;
            $display("FAIL basic_drain: got v=%b d1=%h want v=000 d1=a5", out_valid, out_data1);
        end
    endtask

    task automatic test_stall();
        in_valid = 1'b1; in_sel = 2'b00; in_data = 32'h77;
        step();
        in_data = 32'h99;
        #1;
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_ready: got %b want 0", in_ready);
        end
        step();
        n_tests++;
        if (out_valid[0] !== 1'b1 || out_data0 !== 32'h77) begin
            n_fail++;
            $display("FAIL stall_hold: got v0=%b d0=%h want 1 77", out_valid[0], out_data0);
        end
        in_sel = 2'b10; in_data = 32'h3C;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_other_ready: got %b want 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 3'b101 || out_data2 !== 32'h3C || out_data0 !== 32'h77) begin
            n_fail++;
            $display("FAIL stall_other_out: got v=%b d0=%h d2=%h want 101 77 3c", out_valid, out_data0, out_data2);
        end
        out_ready = 3'b111;
        step();
        out_ready = 3'b000;
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; in_sel = 2'b10; in_data = 32'h10;
        step();
        out_ready = 3'b100;
        for (int i = 0; i < 4; i++) begin
            in_data = W'(32'h11 + i);
            #1;
            n_tests++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_ready%0d: got %b want 1", i, in_ready);
            end
            step();
            n_tests++;
            if (out_valid[2] !== 1'b1 || out_data2 !== W'(32'h11 + i)) begin
                n_fail++;
                $display("FAIL b2b_out%0d: got v2=%b d2=%h want 1 %h", i, out_valid[2], out_data2, 32'h11 + i);
            end
        end
        in_valid = 1'b0;
        step();
        out_ready = 3'b000;
        n_tests++;
        if (out_valid !== 3'b000) begin
            n_fail++;
            $display("FAIL b2b_drain: got %b want 000", out_valid);
        end
    endtask

    task automatic test_illegal();
        in_valid = 1'b1; in_sel = 2'b11; in_data = 32'hFF;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_ready: got %b want 1", in_ready);
        end
        step();
        in_valid = 1'b0;
`ifdef DEMUX3_ERR_EN
        n_tests++;
        if (out_valid !== 3'b000 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_drop: got v=%b err=%b want 000 1", out_valid, err);
        end
        repeat (3) step();
        n_tests++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_sticky: got %b want 1", err);
        end
`else
        n_tests++;
        if (out_valid !== 3'b100 || out_data2 !== 32'hFF) begin
            n_fail++;
            $display("FAIL bad_route: got v=%b d2=%h want 100 ff", out_valid, out_data2);
        end
        out_ready = 3'b100;
        step();
        out_ready = 3'b000;
`endif
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_sel = 2'(k); in_data = W'(32'hC0 + k);
            step();
        end
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 3'b111) begin
            n_fail++;
            $display("FAIL mid_full: got %b want 111", out_valid);
        end
        in_valid = 1'b1; in_sel = 2'b00;
        #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if (out_valid !== 3'b000 || in_ready !== 1'b1 || out_data0 !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: got v=%b rdy=%b d0=%h want 000 1 0", out_valid, in_ready, out_data0);
        end
`ifdef DEMUX3_ERR_EN
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_err: got %b want 0", err);
        end
`endif
        in_valid = 1'b0;
        step();
        reset = 1'b0;
        step();
        n_tests++;
        if (out_valid !== 3'b000) begin
            n_fail++;
            $display("FAIL mid_no_replay: got %b want 000", out_valid);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_sel    = 2'($urandom_range(0, 3));
            in_data   = W'($urandom);
            out_ready = 3'($urandom_range(0, 7));
            step();
        end
        in_valid = 1'b0; out_ready = 3'b111;
        repeat (3) step();
        out_ready = 3'b000;
        n_tests++;
        if (out_valid !== 3'b000 || sb[0].size() != 0 || sb[1].size() != 0 || sb[2].size() != 0) begin
            n_fail++;
            $display("FAIL rand_final: got v=%b left=%0d/%0d/%0d want 000 0/0/0",
                     out_valid, sb[0].size(), sb[1].size(), sb[2].size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        test_random();
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
